// File: rtl/vga_term_decoder.sv
// vga_term_decoder: interprets the captured Z80 byte stream as terminal commands
// and drives the text framebuffer write port and the cursor position.
module vga_term_decoder #(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int ADDR_W     = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_char,
    output logic [7:0]        fb_attr,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy,
    output logic              overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ESC      = 3'd1;
    localparam logic [2:0] S_ESC_ATTR = 3'd2;
    localparam logic [2:0] S_ESC_COL  = 3'd3;
    localparam logic [2:0] S_ESC_ROW  = 3'd4;
    localparam logic [2:0] S_CLEAR    = 3'd5;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS * ROWS - 1);

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PW:0]       wp_q, wp_d, rp_q, rp_d;
    logic [2:0]        state_q, state_d;
    logic [5:0]        col_q, col_d, pcol_q, pcol_d;
    logic [4:0]        row_q, row_d;
    logic [7:0]        attr_q, attr_d, char_q, char_d, fattr_q, fattr_d;
    logic [ADDR_W-1:0] clr_q, clr_d, addr_q, addr_d, cur_addr;
    logic              we_q, we_d, busy_q, busy_d, ovf_q, ovf_d, vld_q;
    logic              push, empty, full, pop, wr, col_end, row_end;
    logic [7:0]        rd_b;

    always_comb begin
        push     = in_valid && !vld_q;
        empty    = wp_q == rp_q;
        full     = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
        pop      = !empty && state_q != S_CLEAR;
        wr       = push && (!full || pop);
        rd_b     = mem[rp_q[PW-1:0]];
        cur_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
        col_end  = col_q == 6'(COLS - 1);
        row_end  = row_q == 5'(ROWS - 1);
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        attr_d   = attr_q;
        pcol_d   = pcol_q;
        clr_d    = clr_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        char_d   = char_q;
        fattr_d  = fattr_q;
        busy_d   = 1'b0;
        ovf_d    = ovf_q || (push && full && !pop);
        wp_d     = wr ? wp_q + 1'b1 : wp_q;
        rp_d     = pop ? rp_q + 1'b1 : rp_q;
        if (state_q == S_CLEAR) begin
            we_d    = 1'b1;
            busy_d  = 1'b1;
            addr_d  = clr_q;
            char_d  = 8'h20;
            fattr_d = attr_q;
            clr_d   = clr_q + 1'b1;
            state_d = clr_q == LAST ? S_IDLE : S_CLEAR;
        end else if (pop) begin
            case (state_q)
                S_IDLE: begin
                    if (rd_b >= 8'h20 && rd_b <= 8'h7E) begin
                        we_d    = 1'b1;
                        addr_d  = cur_addr;
                        char_d  = rd_b;
                        fattr_d = attr_q;
                        col_d   = col_end ? '0 : col_q + 6'd1;
                        row_d   = !col_end ? row_q : row_end ? '0 : row_q + 5'd1;
                    end else if (rd_b == 8'h0D) col_d = '0;
                    else if (rd_b == 8'h0A) row_d = row_end ? '0 : row_q + 5'd1;
                    else if (rd_b == 8'h08) col_d = col_q == '0 ? col_q : col_q - 6'd1;
                    else if (rd_b == 8'h0C) begin
                        col_d   = '0;
                        row_d   = '0;
                        clr_d   = '0;
                        state_d = S_CLEAR;
                    end else if (rd_b == 8'h1B) state_d = S_ESC;
                end
                S_ESC:      state_d = rd_b == 8'h43 ? S_ESC_ATTR : rd_b == 8'h50 ? S_ESC_COL : S_IDLE;
                S_ESC_ATTR: begin
                    attr_d  = rd_b;
                    state_d = S_IDLE;
                end
                S_ESC_COL:  begin
                    pcol_d  = rd_b >= 8'(COLS) ? 6'(COLS - 1) : rd_b[5:0];
                    state_d = S_ESC_ROW;
                end
                S_ESC_ROW:  begin
                    col_d   = pcol_q;
                    row_d   = rd_b >= 8'(ROWS) ? 5'(ROWS - 1) : rd_b[4:0];
                    state_d = S_IDLE;
                end
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk) begin
        if (wr) mem[wp_q[PW-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            attr_q  <= 8'h0F;
            pcol_q  <= '0;
            clr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            char_q  <= '0;
            fattr_q <= 8'h0F;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            attr_q  <= attr_d;
            pcol_q  <= pcol_d;
            clr_q   <= clr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            char_q  <= char_d;
            fattr_q <= fattr_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            vld_q   <= in_valid;
        end
    end

    assign fb_we      = we_q;
    assign fb_addr    = addr_q;
    assign fb_char    = char_q;
    assign fb_attr    = fattr_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = busy_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_vga_term_decoder.sv
// tb_vga_term_decoder: directed checks of byte capture, commands, clear fill,
// overflow and reset abort.
module tb_vga_term_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        fb_we;
    logic [10:0] fb_addr;
    logic [7:0]  fb_char, fb_attr;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy, overflow;
    int          n_cmp = 0;
    int          n_err = 0;
    int          pulses, n_clr, seq_bad;
    logic [31:0] cap_addr, cap_char, cap_attr;

    vga_term_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_char(fb_char), .fb_attr(fb_attr),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        chk("rst_we", fb_we, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_char", fb_char, 0);
        chk("rst_attr", fb_attr, 8'h0F);
        chk("rst_cur", {cursor_col, cursor_row}, 0);
        chk("rst_busy_ovf", {busy, overflow}, 0);
        rst_n = 1'b1;
        // held-high valid must produce a single write
        pulses = 0; in_data = 8'h41; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) in_valid = 1'b0;
            tick();
            if (fb_we) begin
                pulses++;
                cap_addr = 32'(fb_addr); cap_char = 32'(fb_char); cap_attr = 32'(fb_attr);
            end
        end
        chk("hold_pulses", pulses, 1);
        chk("hold_addr", cap_addr, 0);
        chk("hold_char", cap_char, 8'h41);
        chk("hold_attr", cap_attr, 8'h0F);
        chk("hold_cur", {cursor_col, cursor_row}, {6'd1, 5'd0});
        send(8'h1B); send(8'h50); send(8'd39); send(8'd29);
        chk("goto_39_29", {cursor_col, cursor_row}, {6'd39, 5'd29});
        send(8'h42);
        chk("wrap_we", fb_we, 1);
        chk("wrap_addr", fb_addr, 1199);
        chk("wrap_char", fb_char, 8'h42);
        chk("wrap_cur", {cursor_col, cursor_row}, 0);
        send(8'h1B); send(8'h50); send(8'h63); send(8'h05);
        chk("col_clamp", {cursor_col, cursor_row}, {6'd39, 5'd5});
        send(8'h1B); send(8'h43); send(8'h1E);
        chk("attr_no_write", fb_we, 0);
        send(8'h58);
        chk("attr_we", fb_we, 1);
        chk("attr_addr", fb_addr, 239);
        chk("attr_char", fb_char, 8'h58);
        chk("attr_attr", fb_attr, 8'h1E);
        chk("attr_cur", {cursor_col, cursor_row}, {6'd0, 5'd6});
        send(8'h1B); send(8'h50); send(8'h05); send(8'hFF);
        chk("row_clamp", {cursor_col, cursor_row}, {6'd5, 5'd29});
        // clear fill with one byte queued behind it
        send(8'h0C);
        chk("ff_no_write", fb_we, 0);
        n_clr = 0; seq_bad = 0; in_data = 8'h41; in_valid = 1'b1;
        for (int i = 0; i < 1300; i++) begin
            tick();
            in_valid = 1'b0;
            if (busy) begin
                if (!fb_we || 32'(fb_addr) != n_clr || fb_char != 8'h20 || fb_attr != 8'h1E) seq_bad++;
                n_clr++;
            end else if (n_clr > 0) break;
        end
        chk("clr_count", n_clr, 1200);
        chk("clr_seq_bad", seq_bad, 0);
        chk("post_clr_we", fb_we, 1);
        chk("post_clr_addr", fb_addr, 0);
        chk("post_clr_char", fb_char, 8'h41);
        chk("post_clr_cur", {cursor_col, cursor_row}, {6'd1, 5'd0});
        chk("ovf_clean", overflow, 0);
        send(8'h0C);
        for (int k = 0; k < 6; k++) begin
            in_data = 8'(8'h61 + k); in_valid = 1'b1;
            tick();
            if (k == 3) chk("ovf_after4", overflow, 0);
            if (k == 4) chk("ovf_after5", overflow, 1);
            in_valid = 1'b0;
            tick();
        end
        for (int i = 0; i < 1300 && busy; i++) tick();
        chk("ovf_busy_fall", busy, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            chk("drain_we", fb_we, 1);
            chk("drain_addr", fb_addr, k);
            chk("drain_char", fb_char, 8'h61 + k);
        end
        tick();
        chk("drain_done", fb_we, 0);
        chk("drain_cur", {cursor_col, cursor_row}, {6'd4, 5'd0});
        chk("ovf_sticky", overflow, 1);
        send(8'h1B); send(8'h50); send(8'd10); send(8'd29);
        send(8'h0A);
        chk("lf_wrap", {cursor_col, cursor_row}, {6'd10, 5'd0});
        send(8'h08);
        chk("bs", {cursor_col, cursor_row}, {6'd9, 5'd0});
        send(8'h0D);
        chk("cr", {cursor_col, cursor_row}, 0);
        send(8'h08);
        chk("bs_at_0", {cursor_col, cursor_row}, 0);
        chk("ctl_no_write", fb_we, 0);
        send(8'h1B); send(8'h58);
        chk("esc_bad_no_write", fb_we, 0);
        send(8'h01);
        chk("other_discard", fb_we, 0);
        send(8'h5A);
        chk("esc_bad_then_char", {fb_we, fb_addr, fb_char}, {1'b1, 11'd0, 8'h5A});
        send(8'h0C);
        for (int i = 0; i < 10; i++) tick();
        chk("mid_clr_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("rst_clr_we", fb_we, 0);
        chk("rst_clr_busy", busy, 0);
        chk("rst_clr_ovf", overflow, 0);
        chk("rst_clr_attr", fb_attr, 8'h0F);
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("clr_aborted", {fb_we, busy}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
